key_cond: RTL
=============

Name: key_cond

Overview:
Input conditioning stage for the three front-panel buttons. It sits directly upstream of the mode/time-setting logic and replaces the raw modkey/key1/key2 pins with clean, synchronous, one-clk-wide pulses. Per key it provides a synchronizer, a millisecond-sampled debouncer and press-edge detection. It also holds the 2-bit display mode counter (00 normal, 01 stopwatch, 10 set time, 11 alarm), which advances on each modkey press.

Parameters:
SAMPLE_DIV, 20000, clk cycles per debounce sample tick (1 ms at 20 MHz)
DB_MS, 20, consecutive disagreeing sample ticks required to flip a debounced level
HOLD_MS, 500, sample ticks a key1/key2 press must be held before the first auto-repeat pulse
REPEAT_MS, 100, sample ticks between subsequent auto-repeat pulses

Ports:
clk  in  1  system clock, 20 MHz
rst  in  1  synchronous reset, active-high
modkey_n  in  1  raw mode button, active-low, asynchronous
key1_n  in  1  raw button 1, active-low, asynchronous
key2_n  in  1  raw button 2, active-low, asynchronous
mode  out  2  display mode, 00/01/10/11
mod_pulse  out  1  one-clk strobe on a debounced modkey press
k1_pulse  out  1  one-clk strobe on a key1 press or key1 auto-repeat
k2_pulse  out  1  one-clk strobe on a key2 press or key2 auto-repeat
k1_level  out  1  debounced key1, 1 = pressed
k2_level  out  1  debounced key2, 1 = pressed

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: mode=00; all pulses=0; k1_level=k2_level=0; synchronizer flops=1 (released); prescaler, debounce counters and hold counters=0.
- Synchronizer: each raw input passes through a 2-flop synchronizer and is inverted to active-high "pressed".
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps. tick is high for the single clk in which count==SAMPLE_DIV-1.
- Debounce, per key:
  - On tick, if the synced value differs from the debounced level, db_cnt increments; if it equals the level, db_cnt clears.
  - When db_cnt reaches DB_MS-1 and a further disagreeing tick arrives, the level flips and db_cnt clears. A flip therefore needs exactly DB_MS disagreeing ticks.
  - Between ticks, db_cnt holds.
- Press pulse: asserted for exactly one clk, at the clock edge where the debounced level goes 0->1. Releases generate no pulse.
- Mode:
  - On the same edge that asserts mod_pulse, mode <= mode+1, modulo 4 (11 wraps to 00).
  - modkey never auto-repeats.
- Auto-repeat (key1/key2 only, see Optional Feature):
  - hold_cnt clears on the press flip, then increments on each tick while the level is 1.
  - On reaching HOLD_MS, a pulse is emitted and hold_cnt reloads to HOLD_MS-REPEAT_MS, so a pulse follows every REPEAT_MS ticks.
  - Release clears hold_cnt immediately with no pulse. hold_cnt is wide enough that it never overflows.
- Independence and simultaneity: the three keys are fully independent. k1_pulse, k2_pulse and mod_pulse may assert in the same cycle. No priority or masking is applied; downstream resolves conflicts.
- Pulse alignment: all pulses are registered and occur only in the clk cycle that follows a tick.
- Glitches: a bounce shorter than DB_MS ticks never changes the level and never produces a pulse.
- Reset mid-operation: all state returns to reset values.
  - A key held through reset is seen as a fresh press: exactly one pulse DB_MS ticks after rst deasserts, plus synchronizer latency.
  - A partially completed debounce is discarded.

Optional Feature:
Macro KEY_REPEAT_EN.
- Defined: the hold/auto-repeat logic for key1/key2 described above is present.
- Undefined: no hold counters are synthesized. k1_pulse/k2_pulse fire only once per press. HOLD_MS and REPEAT_MS are ignored.
- In both builds, levels, mode and mod_pulse behave identically.

Test Plan:
All scenarios use SAMPLE_DIV=4, DB_MS=3, HOLD_MS=10, REPEAT_MS=4.
1. Reset: assert rst 2 clks with all keys released -> mode=00, all pulses 0, levels 0. Then idle 100 clks -> outputs unchanged.
2. Mode wrap: 5 clean modkey presses, each held 40 clks with 40 clks released between -> 5 single-clk mod_pulse. mode sequence 01,10,11,00,01.
3. Bounce rejection: key1_n toggles low for 2 ticks, high 1 tick, repeated 4 times -> k1_level stays 0, no k1_pulse. A stable 3-tick low then gives exactly 1 pulse.
4. Auto-repeat (KEY_REPEAT_EN defined): hold key2_n low for 30 ticks after debounce -> pulses at hold ticks 10, 14, 18, 22, 26, 30. Release -> no further pulse, k2_level=0 after 3 ticks.
   Same stimulus with KEY_REPEAT_EN undefined -> exactly 1 pulse.
5. Simultaneous: key1_n and key2_n fall in the same clk -> k1_pulse and k2_pulse high in the same single cycle; mode unchanged.
6. Reset mid-press: key1 held, assert rst for 1 clk at hold tick 7 -> no pulse during reset; one k1_pulse exactly 3 ticks later; mode=00.

Source files
------------

// File: rtl/key_cond.sv
// key_cond: 2-flop synchronizer, tick-sampled debounce and press pulses for modkey/key1/key2, plus mode counter.
// Optional macro KEY_REPEAT_EN adds hold-to-auto-repeat on key1/key2.
module key_cond #(
  parameter int SAMPLE_DIV = 20000,
  parameter int DB_MS      = 20,
  parameter int HOLD_MS    = 500,
  parameter int REPEAT_MS  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       modkey_n,
  input  logic       key1_n,
  input  logic       key2_n,
  output logic [1:0] mode,
  output logic       mod_pulse,
  output logic       k1_pulse,
  output logic       k2_pulse,
  output logic       k1_level,
  output logic       k2_level
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = (DB_MS > 1) ? $clog2(DB_MS) : 1;

  // key index: 0 = modkey, 1 = key1, 2 = key2
  logic [2:0]    raw_n;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    pressed;
  logic [2:0]    level;
  logic [2:0]    flip;
  logic [2:0]    press;
  logic [2:0]    rep_hit;
  logic [2:0]    pulse;
  logic [DW-1:0] db_cnt [3];
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign raw_n   = {key2_n, key1_n, modkey_n};
  assign pressed = ~sync2;
  assign tick    = (pre_cnt == PW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
    end
  end

  // flip marks the tick that completes DB_MS consecutive disagreeing samples
  always_comb begin
    flip  = '0;
    press = '0;
    for (int k = 0; k < 3; k++) begin
      flip[k]  = tick && (pressed[k] != level[k]) && (db_cnt[k] == DW'(DB_MS - 1));
      press[k] = flip[k] && !level[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int k = 0; k < 3; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (tick) begin
          if (pressed[k] != level[k]) begin
            if (flip[k]) begin
              level[k]  <= ~level[k];
              db_cnt[k] <= '0;
            end else begin
              db_cnt[k] <= db_cnt[k] + DW'(1);
            end
          end else begin
            db_cnt[k] <= '0;
          end
        end
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int HW = $clog2(HOLD_MS + 1);

  logic [HW-1:0] hold_cnt [2:1];

  // the tick that would reach HOLD_MS emits a pulse and reloads instead
  always_comb begin
    rep_hit = '0;
    for (int k = 1; k < 3; k++) begin
      rep_hit[k] = tick && level[k] && !flip[k] && (hold_cnt[k] == HW'(HOLD_MS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k < 3; k++) begin
        hold_cnt[k] <= '0;
      end
    end else begin
      for (int k = 1; k < 3; k++) begin
        if (!level[k] || flip[k]) begin
          hold_cnt[k] <= '0;
        end else if (tick) begin
          if (hold_cnt[k] == HW'(HOLD_MS - 1)) begin
            hold_cnt[k] <= HW'(HOLD_MS - REPEAT_MS);
          end else begin
            hold_cnt[k] <= hold_cnt[k] + HW'(1);
          end
        end
      end
    end
  end
`else
  assign rep_hit = '0;

  // repeat timing has no effect in this build
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{HOLD_MS, REPEAT_MS};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= '0;
    end else begin
      pulse <= press | rep_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 2'b00;
    end else if (press[0]) begin
      mode <= mode + 2'd1;
    end
  end

  assign mod_pulse = pulse[0];
  assign k1_pulse  = pulse[1];
  assign k2_pulse  = pulse[2];
  assign k1_level  = level[1];
  assign k2_level  = level[2];

endmodule
